// File: rtl/match_ctrl.sv
// Match controller for a 2..4 player paddle game: tracks scores, sequences
// IDLE -> SERVE -> PLAY (-> PAUSE) -> OVER and drives ball enable/serve pulses.
module match_ctrl #(
    parameter int N_PLAYERS    = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 11,
    parameter int SERVE_FRAMES = 60
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           new_frame_i,
    input  logic                           start_i,
    input  logic                           pause_i,
    input  logic [N_PLAYERS-1:0]           goal_i,
    output logic [2:0]                     state_o,
    output logic [N_PLAYERS*SCORE_W-1:0]   score_o,
    output logic                           ball_en_o,
    output logic                           serve_o,
    output logic [$clog2(N_PLAYERS)-1:0]   serve_dir_o,
    output logic [$clog2(N_PLAYERS)-1:0]   winner_o,
    output logic                           winner_vld_o
);

    localparam int IDX_W = $clog2(N_PLAYERS);
    localparam int CNT_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

    // Reject parameter combinations the score/index logic cannot represent.
    if (N_PLAYERS < 2 || N_PLAYERS > 4) begin : g_bad_players
        $error("match_ctrl: N_PLAYERS must be 2..4");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > (2 ** SCORE_W) - 1) begin : g_bad_win
        $error("match_ctrl: WIN_SCORE must be 1..2**SCORE_W-1");
    end
    if (SERVE_FRAMES < 0) begin : g_bad_serve
        $error("match_ctrl: SERVE_FRAMES must be >= 0");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t                         state_q, state_d;
    logic                           resume_play_q, resume_play_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [N_PLAYERS*SCORE_W-1:0]   score_q, score_d;
    logic [IDX_W-1:0]               serve_dir_q, serve_dir_d;
    logic [IDX_W-1:0]               winner_q, winner_d;
    logic                           serve_q, serve_d;
    logic                           ball_en_q;
    logic                           winner_vld_q;
    logic                           start_q, pause_q;

    logic                           start_edge, pause_edge;
    logic                           goal_any;
    logic [IDX_W-1:0]               goal_idx;
    logic [N_PLAYERS-1:0]           goal_sel;
    logic [SCORE_W-1:0]             goal_cur;
    logic [SCORE_W-1:0]             goal_next;
    logic                           goal_win;

    // Edge registers reset high so a key held through reset release is not an edge.
    assign start_edge = start_i & ~start_q;
    assign pause_edge = pause_i & ~pause_q;

    // Pick the lowest-indexed scorer; other simultaneous goal bits are dropped.
    always_comb begin
        goal_idx = '0;
        goal_sel = '0;
        goal_cur = '0;
        for (int i = N_PLAYERS - 1; i >= 0; i--) begin
            if (goal_i[i]) begin
                goal_idx    = IDX_W'(i);
                goal_sel    = '0;
                goal_sel[i] = 1'b1;
                goal_cur    = score_q[i*SCORE_W +: SCORE_W];
            end
        end
    end

    assign goal_any  = |goal_i;
    assign goal_next = goal_cur + SCORE_W'(1);
    assign goal_win  = (goal_next == WIN_VAL);

    // Next-state and next-output logic for the match sequencer.
    always_comb begin
        state_d       = state_q;
        resume_play_d = resume_play_q;
        cnt_d         = cnt_q;
        score_d       = score_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;
        serve_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                score_d = '0;
                if (start_edge) begin
                    state_d = ST_SERVE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SERVE: begin
                if (pause_edge) begin
                    state_d       = ST_PAUSE;
                    resume_play_d = 1'b0;
                end else if (new_frame_i) begin
                    if (cnt_q == '0) begin
                        state_d = ST_PLAY;
                        serve_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // A goal outranks a pause edge arriving in the same cycle.
                if (goal_any) begin
                    for (int i = 0; i < N_PLAYERS; i++) begin
                        if (goal_sel[i]) begin
                            score_d[i*SCORE_W +: SCORE_W] = goal_next;
                        end
                    end
                    serve_dir_d = goal_idx;
                    if (goal_win) begin
                        state_d  = ST_OVER;
                        winner_d = goal_idx;
                    end else begin
                        state_d = ST_SERVE;
                        cnt_d   = CNT_LOAD;
                    end
                end else if (pause_edge) begin
                    state_d       = ST_PAUSE;
                    resume_play_d = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (pause_edge) begin
                    state_d = resume_play_q ? ST_PLAY : ST_SERVE;
                end
            end
            ST_OVER: begin
                if (start_edge) begin
                    state_d = ST_SERVE;
                    score_d = '0;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, score and registered-output update with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            resume_play_q <= 1'b0;
            cnt_q         <= '0;
            score_q       <= '0;
            serve_dir_q   <= '0;
            winner_q      <= '0;
            serve_q       <= 1'b0;
            ball_en_q     <= 1'b0;
            winner_vld_q  <= 1'b0;
            start_q       <= 1'b1;
            pause_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            resume_play_q <= resume_play_d;
            cnt_q         <= cnt_d;
            score_q       <= score_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            serve_q       <= serve_d;
            ball_en_q     <= (state_d == ST_PLAY);
            winner_vld_q  <= (state_d == ST_OVER);
            start_q       <= start_i;
            pause_q       <= pause_i;
        end
    end

    assign state_o      = state_q;
    assign score_o      = score_q;
    assign ball_en_o    = ball_en_q;
    assign serve_o      = serve_q;
    assign serve_dir_o  = serve_dir_q;
    assign winner_o     = winner_q;
    assign winner_vld_o = winner_vld_q;

endmodule
